wildcard_match_table: RTL and testbench

- Programmable, parametrised wildcard pattern classifier.
- Each accepted input word is compared against a table of value/care-mask entries; the lowest-index enabled matching entry supplies the result code.
- Output is registered behind a valid/ready handshake.
- Unmatched inputs are counted in a saturating miss counter rather than silently dropped.
- Sits between a decode source and downstream consumers as the runtime-configurable replacement for fixed wildcard case decoders.

---
 rtl/wmt_pkg.sv | 39 +++
 rtl/wmt_prio_enc.sv | 31 +++
 rtl/wildcard_match_table.sv | 136 +++++++++++++
 tb/tb_wildcard_match_table.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wmt_pkg
// Description : Shared constants, types and entry-match helper for the
//               wildcard_match_table classifier and its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
package wmt_pkg;

  // Default parameter values for the classifier
  localparam int c_WIDTH_DEF   = 2;
  localparam int c_ENTRIES_DEF = 8;
  localparam int c_OUT_W_DEF   = 4;
  localparam int c_CNT_W_DEF   = 8;

  // Widest word the shared match helper handles; narrower words are
  // zero-extended, and their zero mask bits make the padding a wildcard.
  localparam int c_MAX_W = 64;

  typedef logic [c_MAX_W-1:0] wmt_word_t;

  // One entry's hit decision. Only cared bits are examined, and they must be
  // identical (0/1) to the pattern, so an X/Z on a cared bit is a mismatch.
  function automatic logic wmt_entry_hit(input wmt_word_t value,
                                         input wmt_word_t mask,
                                         input logic      en,
                                         input wmt_word_t data);
    logic hit;
    hit = en;
    for (int b = 0; b < c_MAX_W; b++) begin
      if (mask[b] && (data[b] !== value[b])) begin
        hit = 1'b0;
      end
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wmt_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : wmt_prio_enc
// Description : N-wide priority encoder; reports the lowest set request index
//               and whether any request is set. Index is 0 when none is set.
// Revision    : 1.0 - initial release
// ============================================================================
module wmt_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_req,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int IDX_W = $clog2(N);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDX_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wildcard_match_table.sv
`default_nettype none
// ============================================================================
// Module      : wildcard_match_table
// Description : Programmable value/care-mask classifier. Each accepted word
//               is matched against the table, the lowest enabled hitting
//               entry supplies the result, and misses are counted in a
//               saturating counter. Output is registered behind valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module wildcard_match_table
  import wmt_pkg::*;
#(
  parameter int               WIDTH          = c_WIDTH_DEF,
  parameter int               ENTRIES        = c_ENTRIES_DEF,
  parameter int               OUT_W          = c_OUT_W_DEF,
  parameter int               CNT_W          = c_CNT_W_DEF,
  parameter logic [OUT_W-1:0] DEFAULT_RESULT = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(ENTRIES)-1:0] cfg_idx,
  input  logic                       cfg_en,
  input  logic [WIDTH-1:0]           cfg_value,
  input  logic [WIDTH-1:0]           cfg_mask,
  input  logic [OUT_W-1:0]           cfg_result,
  input  logic                       miss_clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_hit,
  output logic [$clog2(ENTRIES)-1:0] out_idx,
  output logic [CNT_W-1:0]           miss_count,
  output logic                       miss_sat
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Table storage
  logic [ENTRIES-1:0] r_en;
  logic [WIDTH-1:0]   r_value  [ENTRIES];
  logic [WIDTH-1:0]   r_mask   [ENTRIES];
  logic [OUT_W-1:0]   r_result [ENTRIES];

  // Output and counter state
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_hit;
  logic [IDX_W-1:0] r_out_idx;
  logic [CNT_W-1:0] r_miss_count;

  // Match path
  logic [ENTRIES-1:0] w_hits;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_any;
  logic [OUT_W-1:0]   w_res;
  logic               w_accept;
  logic               w_sat;

  // Single-entry write; matching this cycle still sees the old contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (rst) begin
        r_en[i]     <= 1'b0;
        r_value[i]  <= '0;
        r_mask[i]   <= '0;
        r_result[i] <= '0;
      end else if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        r_en[i]     <= cfg_en;
        r_value[i]  <= cfg_value;
        r_mask[i]   <= cfg_mask;
        r_result[i] <= cfg_result;
      end
    end
  end

  generate
    for (genvar g = 0; g < ENTRIES; g++) begin : g_hit
      assign w_hits[g] = wmt_entry_hit(wmt_word_t'(r_value[g]),
                                       wmt_word_t'(r_mask[g]),
                                       r_en[g],
                                       wmt_word_t'(in_data));
    end
  endgenerate

  wmt_prio_enc #(
    .N (ENTRIES)
  ) u_prio_enc (
    .i_req (w_hits),
    .o_idx (w_win_idx),
    .o_any (w_any)
  );

  assign w_res    = w_any ? r_result[w_win_idx] : DEFAULT_RESULT;
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_sat    = &r_miss_count;

  // Result register: load on accept, otherwise drain on the consumer handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_hit   <= 1'b0;
      r_out_idx   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_hit   <= w_any;
      r_out_idx   <= w_win_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating miss counter; clear beats a coincident increment
  always_ff @(posedge clk) begin
    if (rst || miss_clr) begin
      r_miss_count <= '0;
    end else if (w_accept && !w_any && !w_sat) begin
      r_miss_count <= r_miss_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_hit    = r_out_hit;
  assign out_idx    = r_out_idx;
  assign miss_count = r_miss_count;
  assign miss_sat   = w_sat;

endmodule
`default_nettype wire

// File: tb/tb_wildcard_match_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_wildcard_match_table
// Description : Self-checking bench for wildcard_match_table: directed vector
//               tables, hand-written handshake/collision/reset sequences and
//               a randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wildcard_match_table;
  import wmt_pkg::*;

  localparam int             W   = 2;
  localparam int             E   = 8;
  localparam int             OW  = 4;
  localparam int             CW  = 2;
  localparam int             IW  = 3;
  localparam logic [OW-1:0]  DEF = 4'd5;
  localparam int             SAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic          cfg_en;
  logic [W-1:0]  cfg_value;
  logic [W-1:0]  cfg_mask;
  logic [OW-1:0] cfg_result;
  logic          miss_clr;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_hit;
  logic [IW-1:0] out_idx;
  logic [CW-1:0] miss_count;
  logic          miss_sat;

  always #5 clk = ~clk;

  wildcard_match_table #(
    .WIDTH          (W),
    .ENTRIES        (E),
    .OUT_W          (OW),
    .CNT_W          (CW),
    .DEFAULT_RESULT (DEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_en     (cfg_en),
    .cfg_value  (cfg_value),
    .cfg_mask   (cfg_mask),
    .cfg_result (cfg_result),
    .miss_clr   (miss_clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_hit    (out_hit),
    .out_idx    (out_idx),
    .miss_count (miss_count),
    .miss_sat   (miss_sat)
  );

  // Reference model: table contents, pending result, miss count
  logic          m_en   [E];
  logic [W-1:0]  m_val  [E];
  logic [W-1:0]  m_mask [E];
  logic [OW-1:0] m_res  [E];
  logic          m_valid;
  logic [OW-1:0] m_data;
  logic          m_hit;
  logic [IW-1:0] m_idx;
  int            m_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [W-1:0]  d;
    logic          hit;
    logic [IW-1:0] idx;
    logic [OW-1:0] res;
    int            cnt;
  } vec_t;

  vec_t v1 [4];
  vec_t v2 [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < E; i++) begin
      m_en[i] = 1'b0; m_val[i] = '0; m_mask[i] = '0; m_res[i] = '0;
    end
    m_valid = 1'b0; m_data = '0; m_hit = 1'b0; m_idx = '0; m_cnt = 0;
  endtask

  // First enabled entry in ascending order that matches decides the result
  function automatic void classify(input logic [W-1:0] d, output logic h,
                                   output logic [IW-1:0] ix, output logic [OW-1:0] r);
    h = 1'b0; ix = '0; r = DEF;
    for (int i = 0; i < E; i++) begin
      if (!h && wmt_entry_hit(wmt_word_t'(m_val[i]), wmt_word_t'(m_mask[i]),
                              m_en[i], wmt_word_t'(d))) begin
        h = 1'b1; ix = IW'(i); r = m_res[i];
      end
    end
  endfunction

  // One clock: check in_ready, predict the edge, then compare outputs after it
  task automatic tick();
    logic acc, h, s_rst, s_clr, s_we, s_en, s_ordy;
    logic [IW-1:0] ix, s_idx;
    logic [OW-1:0] r, s_res;
    logic [W-1:0]  s_val, s_mask;
    #1;
    chk("in_ready", in_ready, !m_valid || out_ready);
    acc = in_valid && (!m_valid || out_ready) && !rst;
    classify(in_data, h, ix, r);
    s_rst = rst; s_clr = miss_clr; s_we = cfg_we; s_idx = cfg_idx; s_en = cfg_en;
    s_val = cfg_value; s_mask = cfg_mask; s_res = cfg_result; s_ordy = out_ready;
    @(posedge clk); #1;
    if (s_rst) begin
      model_reset();
    end else begin
      if (acc) begin
        m_valid = 1'b1; m_data = r; m_hit = h; m_idx = ix;
      end else if (s_ordy) begin
        m_valid = 1'b0;
      end
      if (s_clr) m_cnt = 0;
      else if (acc && !h && m_cnt < SAT) m_cnt++;
      if (s_we) begin
        m_en[s_idx] = s_en; m_val[s_idx] = s_val; m_mask[s_idx] = s_mask; m_res[s_idx] = s_res;
      end
    end
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_hit", out_hit, m_hit);
      chk("out_idx", out_idx, m_idx);
    end
    chk("miss_count", miss_count, m_cnt);
    chk("miss_sat", miss_sat, m_cnt == SAT);
  endtask

  task automatic cfg_write(input logic [IW-1:0] idx, input logic en, input logic [W-1:0] val,
                           input logic [W-1:0] mask, input logic [OW-1:0] res);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_value = val; cfg_mask = mask; cfg_result = res;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [W-1:0] xprobe;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_value = '0; cfg_mask = '0;
    cfg_result = '0; miss_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 4'd0);
    chk("rst_out_hit", out_hit, 1'b0);
    chk("rst_out_idx", out_idx, 3'd0);
    chk("rst_miss_count", miss_count, 2'd0);
    chk("rst_miss_sat", miss_sat, 1'b0);
    out_ready = 1'b1;

    // Priority and wildcard
    v1[0] = '{d: 2'b01, hit: 1'b1, idx: 3'd0, res: 4'd1, cnt: 0};
    v1[1] = '{d: 2'b10, hit: 1'b1, idx: 3'd1, res: 4'd2, cnt: 0};
    v1[2] = '{d: 2'b11, hit: 1'b1, idx: 3'd3, res: 4'd9, cnt: 0};
    v1[3] = '{d: 2'b00, hit: 1'b1, idx: 3'd0, res: 4'd1, cnt: 0};
    cfg_write(3'd0, 1'b1, 2'b00, 2'b10, 4'd1);
    cfg_write(3'd1, 1'b1, 2'b10, 2'b01, 4'd2);
    cfg_write(3'd3, 1'b1, 2'b00, 2'b00, 4'd9);
    for (int i = 0; i < 4; i++) begin
      send(v1[i].d);
      chk("prio_data", out_data, v1[i].res);
      chk("prio_hit", out_hit, v1[i].hit);
      chk("prio_idx", out_idx, v1[i].idx);
      chk("prio_cnt", miss_count, v1[i].cnt);
    end
    tick();

    // Miss counting on an empty table, back-to-back
    do_reset();
    v2[0] = '{d: 2'b00, hit: 1'b0, idx: 3'd0, res: DEF, cnt: 1};
    v2[1] = '{d: 2'b01, hit: 1'b0, idx: 3'd0, res: DEF, cnt: 2};
    v2[2] = '{d: 2'b10, hit: 1'b0, idx: 3'd0, res: DEF, cnt: 3};
    v2[3] = '{d: 2'b11, hit: 1'b0, idx: 3'd0, res: DEF, cnt: 3};
    v2[4] = '{d: 2'b00, hit: 1'b0, idx: 3'd0, res: DEF, cnt: 3};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = v2[i].d;
      tick();
      chk("miss_data", out_data, v2[i].res);
      chk("miss_hit", out_hit, v2[i].hit);
      chk("miss_idx", out_idx, v2[i].idx);
      chk("miss_cnt", miss_count, v2[i].cnt);
      chk("miss_sat_flag", miss_sat, v2[i].cnt == SAT);
    end
    // Clear coinciding with another miss leaves zero
    miss_clr = 1'b1; in_data = 2'b01;
    tick();
    miss_clr = 1'b0; in_valid = 1'b0;
    chk("clr_wins", miss_count, 2'd0);
    tick();

    // Backpressure: distinct exact-match results per word
    cfg_write(3'd0, 1'b1, 2'b00, 2'b11, 4'd1);
    cfg_write(3'd1, 1'b1, 2'b01, 2'b11, 4'd2);
    cfg_write(3'd2, 1'b1, 2'b10, 2'b11, 4'd3);
    cfg_write(3'd3, 1'b1, 2'b11, 2'b11, 4'd4);
    in_valid = 1'b1; in_data = 2'b00;
    tick();
    chk("bp_first", out_data, 4'd1);
    out_ready = 1'b0; in_data = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_ready_low", in_ready, 1'b0);
      chk("bp_hold_data", out_data, 4'd1);
      chk("bp_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_second", out_data, 4'd2);
    in_data = 2'b10;
    tick();
    chk("bp_third", out_data, 4'd3);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", out_valid, 1'b0);

    // Write/accept collision on entry 0
    cfg_write(3'd0, 1'b1, 2'b01, 2'b11, 4'd1);
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b1; cfg_value = 2'b01; cfg_mask = 2'b11;
    cfg_result = 4'd7; in_valid = 1'b1; in_data = 2'b01;
    tick();
    cfg_we = 1'b0;
    chk("coll_old", out_data, 4'd1);
    tick();
    in_valid = 1'b0;
    chk("coll_new", out_data, 4'd7);
    tick();

    // Undefined input bits (only meaningful where the simulator keeps X)
    xprobe = 2'b0x;
    if ($isunknown(xprobe)) begin
      cfg_write(3'd0, 1'b1, 2'b00, 2'b11, 4'd6);
      send(xprobe);
      chk("x_cared_miss", out_hit, 1'b0);
      cfg_write(3'd0, 1'b1, 2'b00, 2'b10, 4'd6);
      send(xprobe);
      chk("x_wild_hit", out_hit, 1'b1);
      chk("x_wild_data", out_data, 4'd6);
      tick();
    end

    // Reset while a result is pending
    cfg_write(3'd0, 1'b1, 2'b00, 2'b00, 4'd8);
    out_ready = 1'b0;
    send(2'b11);
    send(2'b00);
    chk("rst_pend_valid", out_valid, 1'b1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_cnt", miss_count, 2'd0);
    for (int i = 0; i < 4; i++) begin
      send(W'(i));
      chk("rst_mid_miss", out_hit, 1'b0);
      chk("rst_mid_def", out_data, DEF);
    end
    tick();

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_idx    = IW'($urandom_range(0, E - 1));
      cfg_en     = ($urandom_range(0, 3) != 0);
      cfg_value  = W'($urandom);
      cfg_mask   = W'($urandom);
      cfg_result = OW'($urandom);
      miss_clr   = ($urandom_range(0, 15) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = W'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; cfg_we = 1'b0; miss_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
